// File: rtl/vga_scanout_if.sv
// Pixel-side and DAC-side signals of the VGA scanout block.
// master: the scanout itself (raster generator and pin driver).
// slave:  the consumer side (compositor, DAC pins, status readers).
interface vga_scanout_if;
  logic [23:0] rgb_in;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_n;
  logic        VGA_SYNC_n;
  logic        frame_start;
  logic        vblank;
  logic [15:0] frame_count;

  modport master (
    input  rgb_in,
    output hcount, vcount,
    output VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n,
    output frame_start, vblank, frame_count
  );

  modport slave (
    output rgb_in,
    input  hcount, vcount,
    input  VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n,
    input  frame_start, vblank, frame_count
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: raster counters, sync/blank generation delayed to match the
// compositor pipeline, colour gating into the DAC, and frame status.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // {hs, vs, blank_n} while idle: syncs inactive (high), display blanked.
  localparam logic [2:0] TIMING_IDLE = 3'b110;

  logic       phase;
  logic       pixel_en;
  logic [9:0] h_q;
  logic [9:0] v_q;
  logic       raster_wrap;
  logic [2:0] timing_raw;
  logic [2:0] timing_dly;

  // Divide clk by two: phase doubles as the DAC pixel clock.
  // NOTE: every clocked block uses non-blocking (<=) so all registers
  // update from pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) phase <= 1'b0;
    else       phase <= ~phase;
  end

  assign pixel_en    = phase;
  assign raster_wrap = (h_q == H_LAST) && (v_q == V_LAST);

  // Raster counters: column advances each pixel, line advances at column wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pixel_en) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_q <= h_q + 10'd1;
      end
    end
  end

  // Undelayed timing decoded straight from the counters.
  assign timing_raw = {
    ~((h_q >= HS_START) && (h_q < HS_END)),
    ~((v_q >= VS_START) && (v_q < VS_END)),
    (h_q < H_VIS) && (v_q < V_VIS)
  };

  // Delay line that keeps sync/blank in step with the compositor's colour.
  if (PIPE_DEPTH == 0) begin : g_no_pipe
    assign timing_dly = timing_raw;
  end else begin : g_pipe
    logic [2:0] stage_q [PIPE_DEPTH];

    // NOTE: the delay stages are few flops, not a RAM, so they are reset to
    // idle timing; otherwise a reset mid-sync could leak a stale pulse.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DEPTH; i++) stage_q[i] <= TIMING_IDLE;
      end else if (pixel_en) begin
        stage_q[0] <= timing_raw;
        for (int i = 1; i < PIPE_DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign timing_dly = stage_q[PIPE_DEPTH-1];
  end

  // Output register: timing and colour land on the pins together; colour is
  // forced to black whenever the aligned blank_n says the beam is blanked.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.VGA_HS      <= 1'b1;
      bus.VGA_VS      <= 1'b1;
      bus.VGA_BLANK_n <= 1'b0;
      bus.VGA_R       <= '0;
      bus.VGA_G       <= '0;
      bus.VGA_B       <= '0;
    end else if (pixel_en) begin
      bus.VGA_HS      <= timing_dly[2];
      bus.VGA_VS      <= timing_dly[1];
      bus.VGA_BLANK_n <= timing_dly[0];
      bus.VGA_R       <= timing_dly[0] ? bus.rgb_in[23:16] : 8'h00;
      bus.VGA_G       <= timing_dly[0] ? bus.rgb_in[15:8]  : 8'h00;
      bus.VGA_B       <= timing_dly[0] ? bus.rgb_in[7:0]   : 8'h00;
    end
  end

  // Frame status: one-clk pulse and completed-frame count at raster wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.frame_start <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      bus.frame_start <= pixel_en && raster_wrap;
      if (pixel_en && raster_wrap) bus.frame_count <= bus.frame_count + 16'd1;
    end
  end

  assign bus.hcount     = h_q;
  assign bus.vcount     = v_q;
  assign bus.vblank     = (v_q >= V_VIS);
  assign bus.VGA_CLK    = phase;
  assign bus.VGA_SYNC_n = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout using a shrunken raster so that whole
// frames fit in a short run. Expected outputs come from a position-based
// model: everything is a function of clocks elapsed since reset release.
module tb_vga_scanout;

  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VSY = 2, VB = 1;
  localparam int PD = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        sync_n;
    logic        fs;
    logic        vblank;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  vga_scanout_if bus ();

  int          t;          // clk edges since reset was last sampled high
  logic [23:0] last_rgb;   // colour sampled at the most recent pixel edge
  bit          rgb_fixed;
  int          n_checks;
  int          n_fail;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PIPE_DEPTH(PD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.h = bus.hcount;       o.v = bus.vcount;
    o.r = bus.VGA_R;        o.g = bus.VGA_G;        o.b = bus.VGA_B;
    o.vclk = bus.VGA_CLK;   o.hs = bus.VGA_HS;      o.vs = bus.VGA_VS;
    o.blank_n = bus.VGA_BLANK_n; o.sync_n = bus.VGA_SYNC_n;
    o.fs = bus.frame_start; o.vblank = bus.vblank;  o.fc = bus.frame_count;
    return o;
  endfunction

  // Reference: pixel index p = t/2; pins show the raster position PD+1
  // pixels earlier (idle timing before that position exists).
  function automatic obs_t model(int tt, logic [23:0] lr);
    obs_t e;
    int p, q, hq, vq;
    p = tt / 2;
    e.h = 10'(p % HT);
    e.v = 10'((p / HT) % VT);
    q = p - (PD + 1);
    if (q < 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.blank_n = 1'b0;
    end else begin
      hq = q % HT;
      vq = (q / HT) % VT;
      e.hs = !(hq >= HA + HF && hq < HA + HF + HSY);
      e.vs = !(vq >= VA + VF && vq < VA + VF + VSY);
      e.blank_n = (hq < HA) && (vq < VA);
    end
    {e.r, e.g, e.b} = e.blank_n ? lr : 24'h0;
    e.vclk   = 1'(tt % 2);
    e.sync_n = 1'b0;
    e.fs     = (tt % 2 == 0) && (p > 0) && (p % FRAME == 0);
    e.vblank = (p / HT) % VT >= VA;
    e.fc     = 16'((p / FRAME) % 65536);
    return e;
  endfunction

  // One clk: drive inputs, let the edge happen, advance the model clock.
  task automatic tick(input logic rst);
    logic [23:0] drv;
    drv = rgb_fixed ? 24'hFF8000 : 24'($urandom);
    reset = rst;
    bus.rgb_in = drv;
    @(posedge clk);
    if (rst) begin
      t = 0;
      last_rgb = 24'h0;
    end else begin
      t++;
      if (t % 2 == 0) last_rgb = drv;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o, e;
    for (int i = 0; i < 7; i++) begin
      tick(i < 3);
      o = observe(); e = model(t, last_rgb);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_seq[%0d] got=%h exp=%h", i, o, e);
      end
      if (i == 3) begin
        n_checks++;
        if (bus.hcount !== 10'd0 || bus.VGA_CLK !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_clk1 hcount=%0d vga_clk=%b exp 0/1", bus.hcount, bus.VGA_CLK);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (bus.hcount !== 10'd1) begin
          n_fail++;
          $display("FAIL reset_clk2 hcount=%0d exp 1", bus.hcount);
        end
      end
    end
  endtask

  task automatic test_line_timing();
    obs_t o, e;
    int t_hstart, t_fall, t_rise, t_wrap1, t_wrap2;
    logic [9:0] prev_h;
    logic prev_hs;
    t_hstart = -1; t_fall = -1; t_rise = -1; t_wrap1 = -1; t_wrap2 = -1;
    prev_h = bus.hcount; prev_hs = bus.VGA_HS;
    for (int i = 0; i < 6 * HT; i++) begin
      tick(1'b0);
      o = observe(); e = model(t, last_rgb);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL line_cycle t=%0d got=%h exp=%h", t, o, e);
      end
      if (bus.hcount == 10'(HA + HF) && prev_h != 10'(HA + HF) && t_hstart < 0) t_hstart = t;
      if (t_hstart >= 0 && prev_hs && !bus.VGA_HS && t_fall < 0) t_fall = t;
      if (t_fall >= 0 && !prev_hs && bus.VGA_HS && t_rise < 0) t_rise = t;
      if (bus.hcount == 10'd0 && prev_h != 10'd0) begin
        if (t_wrap1 < 0) t_wrap1 = t;
        else if (t_wrap2 < 0) t_wrap2 = t;
      end
      prev_h = bus.hcount; prev_hs = bus.VGA_HS;
    end
    n_checks++;
    if (t_fall - t_hstart !== 2 * (PD + 1)) begin
      n_fail++;
      $display("FAIL hs_fall_latency got=%0d clks exp=%0d", t_fall - t_hstart, 2 * (PD + 1));
    end
    n_checks++;
    if (t_rise - t_fall !== 2 * HSY) begin
      n_fail++;
      $display("FAIL hs_width got=%0d clks exp=%0d", t_rise - t_fall, 2 * HSY);
    end
    n_checks++;
    if (t_wrap1 < 0 || t_wrap2 - t_wrap1 !== 2 * HT) begin
      n_fail++;
      $display("FAIL line_period got=%0d clks exp=%0d", t_wrap2 - t_wrap1, 2 * HT);
    end
  endtask

  task automatic test_frame_status();
    obs_t o, e;
    int pulses, t_vfall, t_vrise, t_fs1, t_fs2;
    logic prev_fs, prev_vs;
    pulses = 0; t_vfall = -1; t_vrise = -1; t_fs1 = -1; t_fs2 = -1;
    tick(1'b1);
    prev_fs = bus.frame_start; prev_vs = bus.VGA_VS;
    for (int i = 0; i < 6 * FRAME + 1; i++) begin
      tick(1'b0);
      o = observe(); e = model(t, last_rgb);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL frame_cycle t=%0d got=%h exp=%h", t, o, e);
      end
      if (bus.frame_start && !prev_fs) begin
        pulses++;
        if (t_fs1 < 0) t_fs1 = t;
        else if (t_fs2 < 0) t_fs2 = t;
      end
      if (bus.frame_start && prev_fs) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_start_width wide pulse at t=%0d exp 1 clk", t);
      end
      if (prev_vs && !bus.VGA_VS && t_vfall < 0) t_vfall = t;
      if (t_vfall >= 0 && !prev_vs && bus.VGA_VS && t_vrise < 0) t_vrise = t;
      prev_fs = bus.frame_start; prev_vs = bus.VGA_VS;
    end
    n_checks++;
    if (pulses !== 3 || bus.frame_count !== 16'd3) begin
      n_fail++;
      $display("FAIL frame_count got pulses=%0d count=%0d exp 3/3", pulses, bus.frame_count);
    end
    n_checks++;
    if (t_vrise - t_vfall !== 2 * VSY * HT) begin
      n_fail++;
      $display("FAIL vs_width got=%0d clks exp=%0d", t_vrise - t_vfall, 2 * VSY * HT);
    end
    n_checks++;
    if (t_fs2 - t_fs1 !== 2 * FRAME) begin
      n_fail++;
      $display("FAIL frame_period got=%0d clks exp=%0d", t_fs2 - t_fs1, 2 * FRAME);
    end
  endtask

  task automatic test_colour_gating();
    int n_vis, n_blank;
    logic [23:0] exp_rgb;
    n_vis = 0; n_blank = 0;
    rgb_fixed = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0);
      if (bus.VGA_BLANK_n === 1'b1) n_vis++;
      else n_blank++;
      exp_rgb = (bus.VGA_BLANK_n === 1'b1 && t > 2 * (PD + 2)) ? 24'hFF8000 : 24'h0;
      if (model(t, 24'h0).blank_n === 1'b1) exp_rgb = 24'hFF8000;
      n_checks++;
      if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== exp_rgb ||
          bus.VGA_BLANK_n !== model(t, 24'h0).blank_n) begin
        n_fail++;
        $display("FAIL colour_gate t=%0d got=%h blank_n=%b exp=%h", t,
                 {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.VGA_BLANK_n, exp_rgb);
      end
    end
    rgb_fixed = 1'b0;
    n_checks++;
    if (n_vis == 0 || n_blank == 0) begin
      n_fail++;
      $display("FAIL colour_coverage visible=%0d blanked=%0d exp both nonzero", n_vis, n_blank);
    end
  endtask

  task automatic reset_at(input int hpos, input int vpos, input string tag);
    obs_t o, e;
    int budget;
    budget = 4 * FRAME;
    while (!(bus.hcount == 10'(hpos) && bus.vcount == 10'(vpos)) && budget > 0) begin
      tick(1'b0);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL %s_reach timeout waiting for (%0d,%0d)", tag, hpos, vpos);
    end
    tick(1'b1);
    o = observe(); e = model(t, last_rgb);
    n_checks++;
    if (o !== e || bus.hcount !== 10'd0 || bus.vcount !== 10'd0 || bus.VGA_HS !== 1'b1 ||
        bus.VGA_VS !== 1'b1 || bus.frame_count !== 16'd0 || bus.VGA_BLANK_n !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_state got=%h exp=%h", tag, o, e);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      o = observe(); e = model(t, last_rgb);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s_restart t=%0d got=%h exp=%h", tag, t, o, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2 * FRAME + 10; i++) tick(1'b0);
    reset_at(HA + HF + 2, 3, "hsync_reset");
    for (int i = 0; i < 2 * FRAME; i++) tick(1'b0);
    reset_at(HA + HF + 2, VA + VF, "vsync_reset");
  endtask

  initial begin
    n_checks = 0; n_fail = 0; t = 0; last_rgb = 24'h0; rgb_fixed = 1'b0;
    reset = 1'b1;
    bus.rgb_in = 24'h0;
    @(negedge clk);
    test_reset();
    test_line_timing();
    test_frame_status();
    test_colour_gating();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
